// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: memOp field positions,
// load/store funct3 codes, the FSM status record and op legality helpers.
package mem_access_unit_pkg;

   localparam int MEMOP_WEN    = 0;
   localparam int MEMOP_WR     = 1;
   localparam int MEMOP_F3_LSB = 2;
   localparam int MEMOP_F3_MSB = 4;

   localparam logic [2:0] MEM_F3_B  = 3'd0;
   localparam logic [2:0] MEM_F3_H  = 3'd1;
   localparam logic [2:0] MEM_F3_W  = 3'd2;
   localparam logic [2:0] MEM_F3_BU = 3'd4;
   localparam logic [2:0] MEM_F3_HU = 3'd5;

   // Live FSM status; a bound checker can watch dut.fsm directly.
   typedef struct packed {
      logic [1:0] state;
      logic [7:0] tmoCnt;
   } mauFsm_t;

   function automatic logic isIllegalOp(input logic [2:0] f3, input logic isWr);
      if (isWr)
         return !(f3 inside {MEM_F3_B, MEM_F3_H, MEM_F3_W});
      return !(f3 inside {MEM_F3_B, MEM_F3_H, MEM_F3_W, MEM_F3_BU, MEM_F3_HU});
   endfunction

   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      case (size)
         2'd1:    return addrLo[0];
         2'd2:    return addrLo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte enables / data replication and
// load byte/half extraction with sign or zero extension.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addrLo,
   input  logic [31:0] storeData,
   input  logic [31:0] loadWord,
   output logic [3:0]  byteEn,
   output logic [31:0] laneData,
   output logic [31:0] loadData
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic        signedLd;

   always_comb begin
      byteSel = loadWord[7:0];
      case (addrLo)
         2'd1:    byteSel = loadWord[15:8];
         2'd2:    byteSel = loadWord[23:16];
         2'd3:    byteSel = loadWord[31:24];
         default: byteSel = loadWord[7:0];
      endcase
   end

   assign halfSel  = addrLo[1] ? loadWord[31:16] : loadWord[15:0];
   // funct3[2] marks the unsigned load variants (LBU/LHU).
   assign signedLd = ~funct3[2];

   always_comb begin
      byteEn   = 4'b1111;
      laneData = storeData;
      loadData = loadWord;
      case (funct3[1:0])
         2'd0: begin
            byteEn   = 4'b0001 << addrLo;
            laneData = {4{storeData[7:0]}};
            loadData = {{24{signedLd & byteSel[7]}}, byteSel};
         end
         2'd1: begin
            byteEn   = 4'b0011 << addrLo;
            laneData = {2{storeData[15:0]}};
            loadData = {{16{signedLd & halfSel[15]}}, halfSel};
         end
         default: begin
            byteEn   = 4'b1111;
            laneData = storeData;
            loadData = loadWord;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one op at a time over a req/gnt/rvalid
// bus, with timeout, alignment and legality checks, and a single WB pulse.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int         XLEN    = 32,
   parameter logic [7:0] TMO_MAX = 8'd255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [4:0]      memOp_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [4:0]      rd_i,
   output logic            dm_req_o,
   output logic            dm_we_o,
   output logic [XLEN-1:0] dm_addr_o,
   output logic [3:0]      dm_be_o,
   output logic [XLEN-1:0] dm_wdata_o,
   input  logic            dm_gnt_i,
   input  logic            dm_rvalid_i,
   input  logic [XLEN-1:0] dm_rdata_i,
   output logic            valid_o,
   output logic [XLEN-1:0] rdata_o,
   output logic [4:0]      rd_o,
   output logic            wb_en_o,
   output logic            misalign_o,
   output logic            illegal_o,
   output logic            bus_err_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   mauFsm_t         fsm;
   logic [2:0]      opF3;
   logic            opWr;
   logic [XLEN-1:0] addrQ, wdataQ, resData;
   logic [4:0]      rdQ;
   logic            resWbEn, resMis, resIll, resErr;

   logic [2:0]      inF3;
   logic            inIll, inMis, inReq, inResp, tmoHit;
   logic [7:0]      tmoNext;
   logic [3:0]      laneBe;
   logic [31:0]     laneWdata, loadData;

   assign inF3    = memOp_i[MEMOP_F3_MSB:MEMOP_F3_LSB];
   assign inIll   = isIllegalOp(inF3, memOp_i[MEMOP_WR]);
   assign inMis   = isMisaligned(inF3[1:0], addr_i[1:0]);
   assign tmoNext = fsm.tmoCnt + 8'd1;
   assign tmoHit  = tmoNext == TMO_MAX;

   mem_lane_align u_lane (
      .funct3    (opF3),
      .addrLo    (addrQ[1:0]),
      .storeData (wdataQ),
      .loadWord  (dm_rdata_i),
      .byteEn    (laneBe),
      .laneData  (laneWdata),
      .loadData  (loadData)
   );

   // Upstream transfer happens on a rising edge with valid_i && ready_o; ready_o
   // is high only in IDLE and never depends on valid_i. valid_o is a one-cycle
   // pulse with no back-pressure from WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm     <= '{state: ST_IDLE, tmoCnt: 8'd0};
         opF3    <= '0;
         opWr    <= 1'b0;
         addrQ   <= '0;
         wdataQ  <= '0;
         rdQ     <= '0;
         resData <= '0;
         resWbEn <= 1'b0;
         resMis  <= 1'b0;
         resIll  <= 1'b0;
         resErr  <= 1'b0;
      end else begin
         case (fsm.state)
            ST_IDLE: if (valid_i) begin
               opF3       <= inF3;
               opWr       <= memOp_i[MEMOP_WR];
               addrQ      <= addr_i;
               wdataQ     <= wdata_i;
               rdQ        <= rd_i;
               resData    <= '0;
               resWbEn    <= 1'b0;
               resMis     <= 1'b0;
               resIll     <= 1'b0;
               resErr     <= 1'b0;
               fsm.tmoCnt <= 8'd0;
               // Legality is judged before alignment so the flags stay exclusive.
               if (!memOp_i[MEMOP_WEN]) begin
                  resData   <= addr_i;
                  resWbEn   <= 1'b1;
                  fsm.state <= ST_RESP;
               end else if (inIll) begin
                  resIll    <= 1'b1;
                  fsm.state <= ST_RESP;
               end else if (inMis) begin
                  resMis    <= 1'b1;
                  fsm.state <= ST_RESP;
               end else begin
                  fsm.state <= ST_REQ;
               end
            end
            ST_REQ: if (dm_gnt_i) begin
               fsm.tmoCnt <= 8'd0;
               fsm.state  <= opWr ? ST_RESP : ST_WAIT;
            end else if (tmoHit) begin
               resErr    <= 1'b1;
               fsm.state <= ST_RESP;
            end else begin
               fsm.tmoCnt <= tmoNext;
            end
            ST_WAIT: if (dm_rvalid_i) begin
               resData   <= loadData;
               resWbEn   <= 1'b1;
               fsm.state <= ST_RESP;
            end else if (tmoHit) begin
               resErr    <= 1'b1;
               fsm.state <= ST_RESP;
            end else begin
               fsm.tmoCnt <= tmoNext;
            end
            default: fsm.state <= ST_IDLE;
         endcase
      end
   end

   assign inReq      = fsm.state == ST_REQ;
   assign inResp     = fsm.state == ST_RESP;
   assign ready_o    = fsm.state == ST_IDLE;

   assign dm_req_o   = inReq;
   assign dm_we_o    = inReq & opWr;
   assign dm_addr_o  = inReq ? {addrQ[XLEN-1:2], 2'b00} : '0;
   assign dm_be_o    = inReq ? laneBe : 4'b0000;
   assign dm_wdata_o = inReq ? laneWdata : '0;

   assign valid_o    = inResp;
   assign rdata_o    = inResp ? resData : '0;
   assign rd_o       = inResp ? rdQ : 5'd0;
   assign wb_en_o    = inResp & resWbEn;
   assign misalign_o = inResp & resMis;
   assign illegal_o  = inResp & resIll;
   assign bus_err_o  = inResp & resErr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, random ops against a
// behavioural model, and hand-written reset / stale-response sequences.
module tb_mem_access_unit;

   localparam int TMO       = 255;
   localparam int CYC_LIMIT = 600;

   typedef struct {
      logic [31:0] rdata, dmAddr, dmWdata;
      logic [3:0]  be;
      logic        we, wbEn, mis, ill, err, isStore;
      int          lat, reqCyc;
   } expT;

   typedef struct {
      logic [31:0] rdata, dmAddr, dmWdata;
      logic [3:0]  be;
      logic        we, wbEn, mis, ill, err;
      logic [4:0]  rd;
      int          lat, reqCyc;
      bit          stableOk, busyOk, pulseOk;
   } obsT;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] addr, wdata, word;
      int          gd, rvd;
      bit          junk;
      logic [4:0]  rd;
      expT         e;
   } vecT;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        valid_i = 1'b0, ready_o;
   logic [4:0]  memOp_i = '0, rd_i = '0, rd_o;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic        dm_req_o, dm_we_o, dm_gnt_i = 1'b0, dm_rvalid_i = 1'b0;
   logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i = '0, rdata_o;
   logic [3:0]  dm_be_o;
   logic        valid_o, wb_en_o, misalign_o, illegal_o, bus_err_o;

   int nCmp = 0, nBad = 0;
   vecT vecs[$];
   logic [31:0] expQ[$];

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .memOp_i(memOp_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
      .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o),
      .dm_wdata_o(dm_wdata_o), .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i),
      .dm_rdata_i(dm_rdata_i), .valid_o(valid_o), .rdata_o(rdata_o), .rd_o(rd_o),
      .wb_en_o(wb_en_o), .misalign_o(misalign_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Spec-level model: lanes by byte arithmetic, latency by counting bus waits.
   function automatic void refModel(input logic [4:0] op, input logic [31:0] addr, wdata, word,
                                    input int gd, rvd, output expT e);
      int f3, a, size;
      bit legal;
      longint unsigned v;
      f3 = int'(op[4:2]);
      a  = int'(addr % 4);
      e = '{rdata: 0, dmAddr: 0, dmWdata: 0, be: 0, we: 0, wbEn: 0, mis: 0, ill: 0, err: 0,
            isStore: 0, lat: 1, reqCyc: 0};
      if (!op[0]) begin
         e.rdata = addr; e.wbEn = 1'b1;
         return;
      end
      legal = op[1] ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
      if (!legal) begin e.ill = 1'b1; return; end
      size = 1 << (f3 % 4);
      if (addr % size != 0) begin e.mis = 1'b1; return; end
      e.dmAddr = addr - a;
      e.we = op[1];
      e.isStore = op[1];
      for (int i = 0; i < 4; i++) begin
         e.be[i] = (i >= a) && (i < a + size);
         e.dmWdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
      if (gd >= TMO) begin
         e.err = 1'b1; e.lat = TMO + 1; e.reqCyc = TMO;
         return;
      end
      e.reqCyc = gd + 1;
      if (op[1]) begin e.lat = 2 + gd; return; end
      if (rvd >= TMO) begin
         e.err = 1'b1; e.lat = 2 + gd + TMO;
         return;
      end
      e.lat = 3 + gd + rvd;
      v = 0;
      for (int k = 0; k < size; k++) v |= longint'(word[8*(a+k) +: 8]) << (8*k);
      if (f3 < 4 && size < 4 && v[8*size-1]) v |= ~((64'd1 << (8*size)) - 64'd1);
      e.wbEn = 1'b1;
      e.rdata = v[31:0];
   endfunction

   // Driver plus bus responder: gnt after gd REQ cycles, rvalid after rvd WAIT cycles.
   task automatic runOp(input logic [4:0] op, input logic [31:0] addr, wdata, word,
                        input int gd, rvd, input bit junk, input logic [4:0] rd, output obsT o);
      int reqCnt, waitCnt;
      bit granted;
      reqCnt = 0; waitCnt = 0; granted = 0;
      o = '{rdata: 0, dmAddr: 0, dmWdata: 0, be: 0, we: 0, wbEn: 0, mis: 0, ill: 0, err: 0,
            rd: 0, lat: -1, reqCyc: 0, stableOk: 1, busyOk: 1, pulseOk: 0};
      @(negedge clk);
      if (!ready_o) o.busyOk = 0;
      valid_i = 1'b1; memOp_i = op; addr_i = addr; wdata_i = wdata; rd_i = rd;
      @(posedge clk);
      for (int cyc = 1; cyc <= CYC_LIMIT; cyc++) begin
         @(negedge clk);
         valid_i = 1'b0; dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = '0;
         if (valid_o) begin
            o.lat = cyc; o.rdata = rdata_o; o.wbEn = wb_en_o; o.rd = rd_o;
            o.mis = misalign_o; o.ill = illegal_o; o.err = bus_err_o;
            break;
         end
         if (ready_o || wb_en_o || misalign_o || illegal_o || bus_err_o || rdata_o != 0)
            o.busyOk = 0;
         if (dm_req_o) begin
            if (reqCnt == 0) begin
               o.be = dm_be_o; o.dmAddr = dm_addr_o; o.we = dm_we_o; o.dmWdata = dm_wdata_o;
            end else if (o.be != dm_be_o || o.dmAddr != dm_addr_o || o.we != dm_we_o ||
                         o.dmWdata != dm_wdata_o) begin
               o.stableOk = 0;
            end
            reqCnt++;
            if (junk) begin dm_rvalid_i = 1'b1; dm_rdata_i = 32'hBAD0_BAD0; end
            if (reqCnt > gd) begin dm_gnt_i = 1'b1; granted = 1; end
         end else if (granted) begin
            waitCnt++;
            if (waitCnt > rvd) begin dm_rvalid_i = 1'b1; dm_rdata_i = word; end
         end
      end
      o.reqCyc = reqCnt;
      @(negedge clk);
      dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = '0;
      o.pulseOk = !valid_o && ready_o;
   endtask

   task automatic checkOp(input string tag, input obsT o, input expT e, input logic [4:0] rd);
      check({tag, ".lat"}, o.lat, e.lat);
      check({tag, ".reqCyc"}, o.reqCyc, e.reqCyc);
      check({tag, ".rdata"}, o.rdata, e.rdata);
      check({tag, ".flags"}, {o.wbEn, o.mis, o.ill, o.err}, {e.wbEn, e.mis, e.ill, e.err});
      check({tag, ".rd"}, o.rd, rd);
      check({tag, ".pulse"}, o.pulseOk, 1);
      check({tag, ".busy"}, o.busyOk, 1);
      if (e.reqCyc > 0) begin
         check({tag, ".dmAddr"}, o.dmAddr, e.dmAddr);
         check({tag, ".be"}, o.be, e.be);
         check({tag, ".we"}, o.we, e.we);
         check({tag, ".stable"}, o.stableOk, 1);
         if (e.isStore) check({tag, ".dmWdata"}, o.dmWdata, e.dmWdata);
      end
   endtask

   task automatic addVec(input logic [4:0] op, input logic [31:0] addr, wdata, word,
                         input int gd, rvd, input bit junk, input logic [31:0] rdata,
                         input logic [3:0] flags, input logic [3:0] be, input logic [31:0] dmw,
                         input int lat, reqc);
      vecT v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.word = word; v.gd = gd; v.rvd = rvd;
      v.junk = junk; v.rd = 5'(vecs.size() + 1);
      v.e.rdata = rdata;
      {v.e.wbEn, v.e.mis, v.e.ill, v.e.err} = flags;
      v.e.be = be; v.e.dmWdata = dmw; v.e.lat = lat; v.e.reqCyc = reqc;
      v.e.dmAddr = addr & 32'hFFFF_FFFC;
      v.e.we = op[1];
      v.e.isStore = op[1];
      vecs.push_back(v);
   endtask

   initial begin
      obsT o;
      expT e;
      vecT v;
      // flags = {wbEn, misalign, illegal, busErr}
      addVec(5'b01011, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4'b0000, 4'hF, 32'hDEADBEEF, 2, 1);
      addVec(5'b00011, 32'h103, 32'h000000A5, 0, 0, 0, 0, 0, 4'b0000, 4'h8, 32'hA5A5A5A5, 2, 1);
      addVec(5'b00001, 32'h202, 0, 32'h12F45678, 0, 0, 0, 32'hFFFFFFF4, 4'b1000, 4'h4, 0, 3, 1);
      addVec(5'b10001, 32'h202, 0, 32'h12F45678, 0, 0, 0, 32'h000000F4, 4'b1000, 4'h4, 0, 3, 1);
      addVec(5'b00101, 32'h202, 0, 32'h12F45678, 0, 0, 0, 32'h000012F4, 4'b1000, 4'hC, 0, 3, 1);
      addVec(5'b01001, 32'h201, 0, 0, 0, 0, 0, 0, 4'b0100, 0, 0, 1, 0);
      addVec(5'b01101, 32'h200, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 1, 0);
      addVec(5'b00000, 32'h55, 0, 0, 0, 0, 0, 32'h55, 4'b1000, 0, 0, 1, 0);
      addVec(5'b00111, 32'h102, 32'h1234BEEF, 0, 2, 0, 0, 0, 4'b0000, 4'hC, 32'hBEEFBEEF, 4, 3);
      addVec(5'b10101, 32'h200, 0, 32'h00008001, 1, 2, 0, 32'h00008001, 4'b1000, 4'h3, 0, 6, 2);
      addVec(5'b00101, 32'h200, 0, 32'h00008001, 0, 0, 0, 32'hFFFF8001, 4'b1000, 4'h3, 0, 3, 1);
      addVec(5'b10011, 32'h101, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 1, 0);
      addVec(5'b01001, 32'h400, 0, 32'hCAFEF00D, 1, 0, 1, 32'hCAFEF00D, 4'b1000, 4'hF, 0, 4, 2);
      addVec(5'b00001, 32'h33, 0, 32'h80123456, 0, 0, 0, 32'hFFFFFF80, 4'b1000, 4'h8, 0, 3, 1);
      addVec(5'b00011, 32'h101, 32'h12345678, 0, 0, 0, 0, 0, 4'b0000, 4'h2, 32'h78787878, 2, 1);
      addVec(5'b01001, 32'h10, 0, 32'h89ABCDEF, 3, 0, 0, 32'h89ABCDEF, 4'b1000, 4'hF, 0, 6, 4);
      addVec(5'b01001, 32'h300, 0, 0, 255, 0, 0, 0, 4'b0001, 4'hF, 0, 256, 255);
      addVec(5'b01001, 32'h304, 0, 0, 0, 1000, 0, 0, 4'b0001, 4'hF, 0, 257, 1);

      // Clock/reset: check reset values while held, then release away from the edge.
      repeat (3) @(negedge clk);
      check("rst.ready", ready_o, 1);
      check("rst.req", dm_req_o, 0);
      check("rst.valid", valid_o, 0);
      check("rst.outs", {rdata_o, wb_en_o, misalign_o, illegal_o, bus_err_o}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         runOp(v.op, v.addr, v.wdata, v.word, v.gd, v.rvd, v.junk, v.rd, o);
         checkOp($sformatf("vec%0d", i), o, v.e, v.rd);
      end

      // Stale rvalid in IDLE after a timeout must not produce a result.
      @(negedge clk);
      dm_rvalid_i = 1'b1; dm_rdata_i = 32'h0BADF00D;
      @(negedge clk);
      dm_rvalid_i = 1'b0;
      check("stale.valid", valid_o, 0);
      check("stale.ready", ready_o, 1);
      refModel(5'b01001, 32'h600, 0, 32'h13579BDF, 0, 0, e);
      runOp(5'b01001, 32'h600, 0, 32'h13579BDF, 0, 0, 0, 5'd3, o);
      checkOp("afterTmo", o, e, 5'd3);

      // Reset while in REQ: request must drop immediately.
      @(negedge clk);
      valid_i = 1'b1; memOp_i = 5'b01001; addr_i = 32'h500; rd_i = 5'd7;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      check("rstReq.reqBefore", dm_req_o, 1);
      rst_n = 1'b0;
      #1;
      check("rstReq.reqDrop", dm_req_o, 0);
      check("rstReq.ready", ready_o, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while in WAIT, then a late rvalid for the aborted load.
      @(negedge clk);
      valid_i = 1'b1; memOp_i = 5'b01001; addr_i = 32'h504; rd_i = 5'd9;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0; dm_gnt_i = 1'b1;
      @(negedge clk);
      dm_gnt_i = 1'b0;
      check("rstWait.busy", ready_o, 0);
      rst_n = 1'b0;
      #1;
      check("rstWait.ready", ready_o, 1);
      check("rstWait.req", dm_req_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dm_rvalid_i = 1'b1; dm_rdata_i = 32'hFEEDFACE;
      @(negedge clk);
      dm_rvalid_i = 1'b0;
      check("rstWait.lateRv", valid_o, 0);
      refModel(5'b00000, 32'h55, 0, 0, 0, 0, e);
      runOp(5'b00000, 32'h55, 0, 0, 0, 0, 0, 5'd11, o);
      checkOp("postRst", o, e, 5'd11);

      // Random ops: expected results queued up front, drained in issue order.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] r;
         r = $urandom();
         v.op = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
         v.addr = r; v.wdata = $urandom(); v.word = $urandom();
         v.gd = $urandom_range(0, 3); v.rvd = $urandom_range(0, 3);
         v.junk = 1'($urandom_range(0, 1)); v.rd = 5'($urandom_range(0, 31));
         refModel(v.op, v.addr, v.wdata, v.word, v.gd, v.rvd, v.e);
         expQ.push_back(v.e.rdata);
         vecs.push_back(v);
      end
      for (int i = 18; i < vecs.size(); i++) begin
         v = vecs[i];
         runOp(v.op, v.addr, v.wdata, v.word, v.gd, v.rvd, v.junk, v.rd, o);
         v.e.rdata = expQ.pop_front();
         checkOp($sformatf("rnd%0d", i - 18), o, v.e, v.rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
